// File: rtl/simd_wb_ctrl_if.sv
// simd_wb_ctrl_if: bundles the issue, ALU-result and register-file write
// signals of the SIMD writeback sequencer. The slave modport is the
// sequencer's view, and the master modport is the view of the surrounding pipeline.
interface simd_wb_ctrl_if #(
    parameter int LANES   = 64,
    parameter int WFID_W  = 6,
    parameter int VADDR_W = 10,
    parameter int SADDR_W = 9
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [WFID_W-1:0]     issue_wfid;
    logic [VADDR_W-1:0]    issue_vgpr_addr;
    logic [SADDR_W-1:0]    issue_sgpr_addr;
    logic                  issue_vgpr_wr_en;
    logic                  issue_vcc_wr_en;
    logic                  issue_sgpr_wr_en;

    logic                  alu_done;
    logic                  alu_ready;
    logic [LANES*32-1:0]   alu_vgpr_data;
    logic [LANES-1:0]      alu_lane_mask;
    logic [LANES-1:0]      alu_scalar_data;

    logic                  vgpr_wr_en;
    logic [VADDR_W-1:0]    vgpr_wr_addr;
    logic [LANES*32-1:0]   vgpr_wr_data;
    logic [LANES-1:0]      vgpr_wr_mask;
    logic                  vcc_wr_en;
    logic                  sgpr_wr_valid;
    logic                  sgpr_wr_ready;
    logic [SADDR_W-1:0]    sgpr_wr_addr;
    logic [LANES-1:0]      sgpr_wr_data;

    logic                  wb_done;
    logic [WFID_W-1:0]     wb_wfid;
    logic                  err_overrun;

    modport slave (
        input  issue_valid, issue_wfid, issue_vgpr_addr, issue_sgpr_addr,
               issue_vgpr_wr_en, issue_vcc_wr_en, issue_sgpr_wr_en,
               alu_done, alu_vgpr_data, alu_lane_mask, alu_scalar_data,
               sgpr_wr_ready,
        output issue_ready, alu_ready,
               vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
               vcc_wr_en, sgpr_wr_valid, sgpr_wr_addr, sgpr_wr_data,
               wb_done, wb_wfid, err_overrun
    );

    modport master (
        output issue_valid, issue_wfid, issue_vgpr_addr, issue_sgpr_addr,
               issue_vgpr_wr_en, issue_vcc_wr_en, issue_sgpr_wr_en,
               alu_done, alu_vgpr_data, alu_lane_mask, alu_scalar_data,
               sgpr_wr_ready,
        input  issue_ready, alu_ready,
               vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
               vcc_wr_en, sgpr_wr_valid, sgpr_wr_addr, sgpr_wr_data,
               wb_done, wb_wfid, err_overrun
    );
endinterface

// File: rtl/simd_wb_ctrl.sv
// simd_wb_ctrl: writeback sequencer. Issued instructions queue a descriptor
// (wavefront, destinations, write enables). Each in-order ALU result is paired
// with the oldest descriptor. The result is then written out in a fixed order:
// VGPR, then VCC, then SGPR. A one-cycle retire pulse follows the writes.
module simd_wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter int LANES   = 64,
    parameter int WFID_W  = 6,
    parameter int VADDR_W = 10,
    parameter int SADDR_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    simd_wb_ctrl_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DESC_W = WFID_W + VADDR_W + SADDR_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VGPR,
        ST_VCC,
        ST_SGPR,
        ST_RETIRE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [DESC_W-1:0]    r_fifo [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_alu_ready;

    logic [DESC_W-1:0]    w_head;
    logic [WFID_W-1:0]    w_head_wfid;
    logic [VADDR_W-1:0]   w_head_vaddr;
    logic [SADDR_W-1:0]   w_head_saddr;
    logic                 w_head_v;
    logic                 w_head_c;
    logic                 w_head_s;

    logic [WFID_W-1:0]    r_wfid;
    logic [VADDR_W-1:0]   r_vaddr;
    logic [SADDR_W-1:0]   r_saddr;
    logic                 r_v_en;
    logic                 r_c_en;
    logic                 r_s_en;
    logic [LANES*32-1:0]  r_vdata;
    logic [LANES-1:0]     r_mask;
    logic [LANES-1:0]     r_scalar;
    logic                 r_err;

    assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_alu_ready = (r_state == ST_IDLE) && !w_empty;
    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign w_push      = bus.issue_valid && !w_full;
    assign w_pop       = bus.alu_done && w_alu_ready;

    assign w_head = r_fifo[r_rd_ptr];
    assign {w_head_wfid, w_head_vaddr, w_head_saddr,
            w_head_v, w_head_c, w_head_s} = w_head;

    // Descriptor storage; contents need no reset because the count decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {bus.issue_wfid, bus.issue_vgpr_addr, bus.issue_sgpr_addr,
                                 bus.issue_vgpr_wr_en, bus.issue_vcc_wr_en,
                                 bus.issue_sgpr_wr_en};
        end
    end

    // FIFO pointers and occupancy; a reset drops every pending descriptor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Capture the accepted result together with its descriptor for the write stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wfid   <= '0;
            r_vaddr  <= '0;
            r_saddr  <= '0;
            r_v_en   <= 1'b0;
            r_c_en   <= 1'b0;
            r_s_en   <= 1'b0;
            r_vdata  <= '0;
            r_mask   <= '0;
            r_scalar <= '0;
        end else if (w_pop) begin
            r_wfid   <= w_head_wfid;
            r_vaddr  <= w_head_vaddr;
            r_saddr  <= w_head_saddr;
            r_v_en   <= w_head_v;
            r_c_en   <= w_head_c;
            r_s_en   <= w_head_s;
            r_vdata  <= bus.alu_vgpr_data;
            r_mask   <= bus.alu_lane_mask;
            r_scalar <= bus.alu_scalar_data;
        end
    end

    // Sticky overrun flag: a result arrived when no descriptor could take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_err <= 1'b0;
        else if (bus.alu_done && !w_alu_ready) r_err <= 1'b1;
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Walk the enabled write stages in order and skip disabled ones.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    if (w_head_v)      w_next_state = ST_VGPR;
                    else if (w_head_c) w_next_state = ST_VCC;
                    else if (w_head_s) w_next_state = ST_SGPR;
                    else               w_next_state = ST_RETIRE;
                end
            end
            ST_VGPR: begin
                if (r_c_en)      w_next_state = ST_VCC;
                else if (r_s_en) w_next_state = ST_SGPR;
                else             w_next_state = ST_RETIRE;
            end
            ST_VCC: begin
                if (r_s_en) w_next_state = ST_SGPR;
                else        w_next_state = ST_RETIRE;
            end
            ST_SGPR: begin
                if (bus.sgpr_wr_ready) w_next_state = ST_RETIRE;
            end
            ST_RETIRE: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    assign bus.issue_ready   = !w_full;
    assign bus.alu_ready     = w_alu_ready;
    assign bus.err_overrun   = r_err;

    assign bus.vgpr_wr_en    = (r_state == ST_VGPR);
    assign bus.vgpr_wr_addr  = (r_state == ST_VGPR) ? r_vaddr : '0;
    assign bus.vgpr_wr_data  = (r_state == ST_VGPR) ? r_vdata : '0;
    assign bus.vgpr_wr_mask  = (r_state == ST_VGPR) ? r_mask  : '0;

    assign bus.vcc_wr_en     = (r_state == ST_VCC);
    assign bus.sgpr_wr_valid = (r_state == ST_SGPR);
    assign bus.sgpr_wr_addr  = (r_state == ST_SGPR) ? r_saddr : '0;
    assign bus.sgpr_wr_data  = ((r_state == ST_VCC) || (r_state == ST_SGPR)) ? r_scalar : '0;

    assign bus.wb_done       = (r_state == ST_RETIRE);
    assign bus.wb_wfid       = (r_state == ST_RETIRE) ? r_wfid : '0;
endmodule

// File: tb/tb_simd_wb_ctrl.sv
// tb_simd_wb_ctrl: directed stimulus for the writeback sequencer. Each accepted
// ALU result queues its expected write and retire events with absolute cycle
// numbers. A negedge monitor pops those events and compares them whenever
// the DUT strobes a write port or retires.
module tb_simd_wb_ctrl;
    localparam int DEPTH   = 4;
    localparam int LANES   = 64;
    localparam int WFID_W  = 6;
    localparam int VADDR_W = 10;
    localparam int SADDR_W = 9;

    localparam int K_VGPR   = 0;
    localparam int K_VCC    = 1;
    localparam int K_SGPR   = 2;
    localparam int K_RETIRE = 3;

    typedef struct {
        logic [WFID_W-1:0]  wfid;
        logic [VADDR_W-1:0] vaddr;
        logic [SADDR_W-1:0] saddr;
        logic               v;
        logic               c;
        logic               s;
    } desc_t;

    typedef struct {
        int                  kind;
        int                  cyc;
        logic [VADDR_W-1:0]  vaddr;
        logic [SADDR_W-1:0]  saddr;
        logic [LANES*32-1:0] vdata;
        logic [LANES-1:0]    mask;
        logic [LANES-1:0]    scalar;
        logic [WFID_W-1:0]   wfid;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    desc_t descQ[$];
    ev_t   expQ[$];
    int    nChecks = 0;
    int    nFails  = 0;
    int    cyc     = 0;
    int    sgprValidCycles = 0;

    simd_wb_ctrl_if #(.LANES(LANES), .WFID_W(WFID_W), .VADDR_W(VADDR_W), .SADDR_W(SADDR_W)) bus ();

    simd_wb_ctrl #(
        .DEPTH(DEPTH), .LANES(LANES), .WFID_W(WFID_W), .VADDR_W(VADDR_W), .SADDR_W(SADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock and a cycle counter that advances on each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case some wait escapes its bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LANES*32-1:0] mkData(input int seed);
        logic [LANES*32-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = 32'(seed) * 32'h0001_9E37 + 32'(i);
        return d;
    endfunction

    // Push one descriptor through the issue handshake and record it in the model.
    task automatic applyStimulus(input logic [WFID_W-1:0] wfid, input logic [VADDR_W-1:0] vaddr,
                                 input logic [SADDR_W-1:0] saddr,
                                 input logic v, input logic c, input logic s);
        desc_t d;
        int    waited;
        d = '{wfid: wfid, vaddr: vaddr, saddr: saddr, v: v, c: c, s: s};
        bus.issue_wfid       = wfid;
        bus.issue_vgpr_addr  = vaddr;
        bus.issue_sgpr_addr  = saddr;
        bus.issue_vgpr_wr_en = v;
        bus.issue_vcc_wr_en  = c;
        bus.issue_sgpr_wr_en = s;
        bus.issue_valid      = 1'b1;
        waited = 0;
        while (!bus.issue_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) checkOutput("issue_ready_timeout", 64'd0, 64'd1);
        else               descQ.push_back(d);
        tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic waitAluReady(output bit ok);
        int waited;
        waited = 0;
        while (!bus.alu_ready && waited < 100) begin
            tick();
            waited++;
        end
        ok = (waited < 100);
        if (!ok) checkOutput("alu_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (expQ.size() > 0 && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
        tick();
    endtask

    // Deliver one ALU result for the oldest descriptor and queue its expected events.
    task automatic runResult(input int seed, input int stall, input bit extraDone);
        desc_t d;
        ev_t   e;
        bit    ok;
        int    base;
        int    t;
        waitAluReady(ok);
        if (!ok) return;
        if (descQ.size() == 0) begin
            $display("[TB] no descriptor in model, result skipped");
            return;
        end
        d    = descQ.pop_front();
        base = cyc;
        e.vaddr  = d.vaddr;
        e.saddr  = d.saddr;
        e.wfid   = d.wfid;
        e.vdata  = mkData(seed);
        e.mask   = 64'hF0F0_3C3C_FFFF_0001 ^ 64'(seed);
        e.scalar = 64'h1234_5678_9ABC_DEF0 + 64'(seed);
        bus.alu_vgpr_data   = e.vdata;
        bus.alu_lane_mask   = e.mask;
        bus.alu_scalar_data = e.scalar;
        bus.sgpr_wr_ready   = (stall == 0);
        bus.alu_done        = 1'b1;
        t = base + 1;
        if (d.v) begin e.kind = K_VGPR; e.cyc = t; expQ.push_back(e); t++; end
        if (d.c) begin e.kind = K_VCC;  e.cyc = t; expQ.push_back(e); t++; end
        if (d.s) begin e.kind = K_SGPR; e.cyc = t + stall; expQ.push_back(e); t = t + stall + 1; end
        e.kind = K_RETIRE;
        e.cyc  = t;
        expQ.push_back(e);
        tick();
        bus.alu_done = extraDone;
        if (extraDone) begin
            tick();
            bus.alu_done = 1'b0;
        end
        if (stall > 0) begin
            while (cyc < base + 1 + int'(d.v) + int'(d.c) + stall) tick();
            bus.sgpr_wr_ready = 1'b1;
        end
    endtask

    // Monitor: compare every write strobe and retire against the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        int  n;
        if (!rst) begin
            n = int'(bus.vgpr_wr_en) + int'(bus.vcc_wr_en) + int'(bus.sgpr_wr_valid) + int'(bus.wb_done);
            if (n > 0) checkOutput("single_strobe", 64'(n), 64'd1);
            if (bus.sgpr_wr_valid) sgprValidCycles++;
            k = -1;
            if (bus.vgpr_wr_en)         k = K_VGPR;
            else if (bus.vcc_wr_en)     k = K_VCC;
            else if (bus.sgpr_wr_valid) k = K_SGPR;
            else if (bus.wb_done)       k = K_RETIRE;
            if (k >= 0) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_event: got kind %0d required none (cycle %0d)", k, cyc);
                end else if (k == K_SGPR && !bus.sgpr_wr_ready) begin
                    e = expQ[0];
                    checkOutput("stall_kind", 64'(k), 64'(e.kind));
                    checkOutput("stall_sgpr_addr", 64'(bus.sgpr_wr_addr), 64'(e.saddr));
                    checkOutput("stall_sgpr_data", 64'(bus.sgpr_wr_data), 64'(e.scalar));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event_kind", 64'(k), 64'(e.kind));
                    checkOutput("event_cycle", 64'(cyc), 64'(e.cyc));
                    case (k)
                        K_VGPR: begin
                            checkOutput("vgpr_addr", 64'(bus.vgpr_wr_addr), 64'(e.vaddr));
                            checkOutput("vgpr_mask", 64'(bus.vgpr_wr_mask), 64'(e.mask));
                            nChecks++;
                            if (bus.vgpr_wr_data !== e.vdata) begin
                                nFails++;
                                $display("[TB] FAIL vgpr_data: got low %0h required low %0h (cycle %0d)",
                                         bus.vgpr_wr_data[63:0], e.vdata[63:0], cyc);
                            end
                        end
                        K_VCC: checkOutput("vcc_data", 64'(bus.sgpr_wr_data), 64'(e.scalar));
                        K_SGPR: begin
                            checkOutput("sgpr_addr", 64'(bus.sgpr_wr_addr), 64'(e.saddr));
                            checkOutput("sgpr_data", 64'(bus.sgpr_wr_data), 64'(e.scalar));
                        end
                        default: checkOutput("wb_wfid", 64'(bus.wb_wfid), 64'(e.wfid));
                    endcase
                end
            end
        end
    end

    // Directed sequence of scenarios.
    initial begin
        bus.issue_valid = 1'b0; bus.issue_wfid = '0; bus.issue_vgpr_addr = '0;
        bus.issue_sgpr_addr = '0; bus.issue_vgpr_wr_en = 1'b0; bus.issue_vcc_wr_en = 1'b0;
        bus.issue_sgpr_wr_en = 1'b0; bus.alu_done = 1'b0; bus.alu_vgpr_data = '0;
        bus.alu_lane_mask = '0; bus.alu_scalar_data = '0; bus.sgpr_wr_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        checkOutput("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        checkOutput("rst_vgpr_wr_en", 64'(bus.vgpr_wr_en), 64'd0);
        checkOutput("rst_vcc_wr_en", 64'(bus.vcc_wr_en), 64'd0);
        checkOutput("rst_sgpr_wr_valid", 64'(bus.sgpr_wr_valid), 64'd0);
        checkOutput("rst_wb_done", 64'(bus.wb_done), 64'd0);
        checkOutput("rst_wb_wfid", 64'(bus.wb_wfid), 64'd0);
        checkOutput("rst_err_overrun", 64'(bus.err_overrun), 64'd0);
        checkOutput("rst_sgpr_wr_data", 64'(bus.sgpr_wr_data), 64'd0);
        checkOutput("rst_vgpr_wr_mask", 64'(bus.vgpr_wr_mask), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] vgpr-only descriptor");
        applyStimulus(6'd5, 10'h020, 9'h000, 1'b1, 1'b0, 1'b0);
        checkOutput("alu_ready_after_push", 64'(bus.alu_ready), 64'd1);
        tick();
        tick();
        runResult(1, 0, 1'b0);

        $display("[TB] vgpr plus vcc descriptor");
        applyStimulus(6'd12, 10'h111, 9'h000, 1'b1, 1'b1, 1'b0);
        runResult(2, 0, 1'b0);

        $display("[TB] sgpr compare with stalled ready");
        applyStimulus(6'd33, 10'h000, 9'h014, 1'b0, 1'b0, 1'b1);
        waitDrain();
        sgprValidCycles = 0;
        runResult(3, 4, 1'b0);
        waitDrain();
        checkOutput("sgpr_valid_cycles", 64'(sgprValidCycles), 64'd5);

        $display("[TB] all-zero enables");
        applyStimulus(6'd7, 10'h003, 9'h004, 1'b0, 1'b0, 1'b0);
        runResult(4, 0, 1'b0);
        waitDrain();

        $display("[TB] fill, full-with-pop, pointer wrap");
        applyStimulus(6'd20, 10'h0A0, 9'h010, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'd21, 10'h0A1, 9'h012, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'd22, 10'h0A2, 9'h0F0, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'd23, 10'h0A3, 9'h1F4, 1'b1, 1'b1, 1'b1);
        checkOutput("full_issue_ready", 64'(bus.issue_ready), 64'd0);
        bus.issue_wfid = 6'd24; bus.issue_vgpr_addr = 10'h2A4; bus.issue_sgpr_addr = 9'h0C6;
        bus.issue_vgpr_wr_en = 1'b1; bus.issue_vcc_wr_en = 1'b0; bus.issue_sgpr_wr_en = 1'b1;
        bus.issue_valid = 1'b1;
        tick();
        checkOutput("full_hold_issue_ready", 64'(bus.issue_ready), 64'd0);
        runResult(5, 0, 1'b0);
        checkOutput("after_pop_issue_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        descQ.push_back('{wfid: 6'd24, vaddr: 10'h2A4, saddr: 9'h0C6, v: 1'b1, c: 1'b0, s: 1'b1});
        checkOutput("refull_issue_ready", 64'(bus.issue_ready), 64'd0);
        runResult(6, 0, 1'b0);
        runResult(7, 0, 1'b0);
        runResult(8, 2, 1'b0);
        runResult(9, 1, 1'b0);
        waitDrain();

        $display("[TB] overrun on empty fifo and during vgpr stage");
        checkOutput("err_before_overrun", 64'(bus.err_overrun), 64'd0);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        checkOutput("err_after_empty_done", 64'(bus.err_overrun), 64'd1);
        checkOutput("alu_ready_still_empty", 64'(bus.alu_ready), 64'd0);
        applyStimulus(6'd40, 10'h3FF, 9'h1FE, 1'b1, 1'b1, 1'b0);
        runResult(10, 0, 1'b1);
        waitDrain();
        checkOutput("err_sticky", 64'(bus.err_overrun), 64'd1);

        $display("[TB] reset while sgpr write waits");
        begin
            bit  ok;
            ev_t e;
            applyStimulus(6'd50, 10'h001, 9'h0AA, 1'b0, 1'b0, 1'b1);
            applyStimulus(6'd51, 10'h002, 9'h000, 1'b1, 1'b0, 1'b0);
            waitAluReady(ok);
            if (ok) begin
                void'(descQ.pop_front());
                e.kind = K_SGPR; e.cyc = -1; e.vaddr = '0; e.saddr = 9'h0AA;
                e.vdata = '0; e.mask = '0; e.scalar = 64'hDEAD_BEEF_0BAD_F00D; e.wfid = 6'd50;
                expQ.push_back(e);
                bus.alu_scalar_data = e.scalar;
                bus.sgpr_wr_ready   = 1'b0;
                bus.alu_done        = 1'b1;
                tick();
                bus.alu_done = 1'b0;
                checkOutput("sgpr_waiting_valid", 64'(bus.sgpr_wr_valid), 64'd1);
                tick();
                tick();
            end
            rst = 1'b1;
            expQ.delete();
            descQ.delete();
            #1;
            checkOutput("midrst_sgpr_wr_valid", 64'(bus.sgpr_wr_valid), 64'd0);
            checkOutput("midrst_sgpr_wr_data", 64'(bus.sgpr_wr_data), 64'd0);
            checkOutput("midrst_sgpr_wr_addr", 64'(bus.sgpr_wr_addr), 64'd0);
            checkOutput("midrst_wb_done", 64'(bus.wb_done), 64'd0);
            checkOutput("midrst_alu_ready", 64'(bus.alu_ready), 64'd0);
            checkOutput("midrst_issue_ready", 64'(bus.issue_ready), 64'd1);
            checkOutput("midrst_err_overrun", 64'(bus.err_overrun), 64'd0);
            tick();
            rst = 1'b0;
            bus.sgpr_wr_ready = 1'b1;
            tick();
            checkOutput("postrst_alu_ready", 64'(bus.alu_ready), 64'd0);
            applyStimulus(6'd52, 10'h055, 9'h022, 1'b1, 1'b0, 1'b1);
            runResult(11, 1, 1'b0);
            waitDrain();
        end

        repeat (3) tick();
        checkOutput("leftover_expected", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
